quad_decoder_counter: RTL

//   Decodes a 2-phase quadrature input (A/B, e.g. rotary encoder) into up/down steps.

---
 rtl/quad_decoder_counter_pkg.sv | 31 +++
 rtl/quad_decoder_counter_phase_filter.sv | 65 ++++++
 rtl/quad_decoder_counter.sv | 98 +++++++++
 3 files changed

// File: rtl/quad_decoder_counter_pkg.sv
// Shared AB phase codes, decode result encoding and the quadrature decode function.
// Latency: none (constants and combinational helper only).
// Backpressure: not applicable.
package quad_decoder_counter_pkg;

  // {A,B} phase codes
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_10 = 2'b10;
  localparam logic [1:0] AB_11 = 2'b11;

  typedef enum logic [1:0] {
    DEC_NONE = 2'd0,
    DEC_UP   = 2'd1,
    DEC_DN   = 2'd2,
    DEC_ERR  = 2'd3
  } dec_e;

  // Classify a transition between two accepted AB values.
  // A leading B counts up, B leading A counts down, both bits flipping is illegal.
  function automatic dec_e quad_decode(input logic [1:0] from_ab, input logic [1:0] to_ab);
    dec_e res;
    case ({from_ab, to_ab})
      {AB_00, AB_10}, {AB_10, AB_11}, {AB_11, AB_01}, {AB_01, AB_00}: res = DEC_UP;
      {AB_00, AB_01}, {AB_01, AB_11}, {AB_11, AB_10}, {AB_10, AB_00}: res = DEC_DN;
      default: res = ((from_ab ^ to_ab) == 2'b11) ? DEC_ERR : DEC_NONE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/quad_decoder_counter_phase_filter.sv
// Synchronises the 2-bit AB bus and accepts a new value once it has been stable long enough.
// Latency: SYNC_STAGES flops, then FILT_CYCLES cycles of stability before accept_o fires.
// Backpressure: none; accept_o is a single-cycle strobe that is never stalled.
module quad_phase_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ab_i,      // raw {A,B}, asynchronous to clk
  output logic [1:0] ab_q_o,    // last accepted value (before this cycle's accept)
  output logic [1:0] ab_s_o,    // synchronised value
  output logic       accept_o   // ab_s_o is accepted this cycle
);

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] FILT_MAX = CW'(FILT_CYCLES);

  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic [1:0]                  ab_s;
  logic [1:0]                  ab_p_q;   // ab_s one cycle ago, detects a change
  logic [1:0]                  ab_q, ab_q_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        accept;

  assign ab_s = sync_q[SYNC_STAGES-1];

  // Stability counter: restart on any change, accept once it has counted FILT_CYCLES.
  always_comb begin
    cnt_d  = cnt_q;
    ab_q_d = ab_q;
    accept = 1'b0;
    if (ab_s == ab_q) begin
      cnt_d = '0;
    end else if (ab_s != ab_p_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q == FILT_MAX) begin
      accept = 1'b1;
      ab_q_d = ab_s;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchroniser chain and filter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      ab_p_q <= 2'b00;
      ab_q   <= 2'b00;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ab_i};
      ab_p_q <= ab_s;
      ab_q   <= ab_q_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ab_q_o   = ab_q;
  assign ab_s_o   = ab_s;
  assign accept_o = accept;

endmodule

// File: rtl/quad_decoder_counter.sv
// Quadrature decoder driving a loadable wrapping position counter, with a sticky illegal-jump flag.
// Latency: stable phase edge to count/step update is SYNC_STAGES+FILT_CYCLES+1 clk.
// Backpressure: none; steps are applied immediately, load overrides a coincident step.
module quad_decoder_counter
  import quad_decoder_counter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phase_a,
  input  logic             phase_b,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  logic [1:0]       ab_q, ab_s;
  logic             accept;
  dec_e             dec;
  logic             init_q, init_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;

  quad_phase_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_CYCLES(FILT_CYCLES)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .ab_i    ({phase_a, phase_b}),
    .ab_q_o  (ab_q),
    .ab_s_o  (ab_s),
    .accept_o(accept)
  );

  assign dec = quad_decode(ab_q, ab_s);

  // Decode the accepted transition and work out the next counter / flag values.
  always_comb begin
    init_d  = init_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    err_d   = err_q & ~clr_err;
    count_d = count_q;
    if (accept) begin
      if (init_q) begin
        // First accept after reset only establishes the reference phase.
        init_d = 1'b0;
      end else begin
        case (dec)
          DEC_UP:  begin step_d = 1'b1; dir_d = 1'b1; end
          DEC_DN:  begin step_d = 1'b1; dir_d = 1'b0; end
          DEC_ERR: err_d = 1'b1;   // set beats a same-cycle clr_err
          default: ;
        endcase
      end
    end
    if (load) begin
      count_d = data;   // a coincident step is still reported on step/dir
    end else if (step_d && dir_d) begin
      count_d = count_q + WIDTH'(1);
    end else if (step_d) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Output and init registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q  <= 1'b1;
      count_q <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      init_q  <= init_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign step  = step_q;
  assign err   = err_q;

endmodule
